// File: rtl/uart_rx_top.sv
// UART receive engine: 16x oversampled deserialiser for 5-8 data bits with
// optional parity, single stop-bit check and break detection.
module uart_rx_top #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_pulse,
    input  logic       rx,
    input  logic       pen,
    input  logic       eps,
    input  logic       sticky_parity,
    input  logic [1:0] wls,
    output logic       push,
    output logic [7:0] dout,
    output logic       pe,
    output logic       fe,
    output logic       bi
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Expected parity bit; stick parity forces the inverse of eps.
    function automatic logic exp_parity(input logic [7:0] data,
                                        input logic       even,
                                        input logic       stick);
        logic res;
        if (stick) begin
            res = ~even;
        end else if (even) begin
            res = ^data;
        end else begin
            res = ~(^data);
        end
        return res;
    endfunction

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   rxs_s;

    state_t     state_r,    state_s;
    logic [3:0] count_r,    count_s;
    logic [2:0] bitcnt_r,   bitcnt_s;
    logic [7:0] shift_r,    shift_s;
    logic       armed_r,    armed_s;
    logic [1:0] wls_r,      wls_s;
    logic       pen_r,      pen_s;
    logic       eps_r,      eps_s;
    logic       stick_r,    stick_s;
    logic       par_err_r,  par_err_s;
    logic       par_zero_r, par_zero_s;
    logic       push_r,     push_s;
    logic [7:0] dout_r,     dout_s;
    logic       pe_r,       pe_s;
    logic       fe_r,       fe_s;
    logic       bi_r,       bi_s;
    logic [2:0] align_s;

    assign rxs_s   = sync_r[SYNC_STAGES-1];
    // Bits arrive at the top of the shift register; move them down to bit 0.
    assign align_s = 3'd3 - {1'b0, wls_r};

    assign push = push_r;
    assign dout = dout_r;
    assign pe   = pe_r;
    assign fe   = fe_r;
    assign bi   = bi_r;

    // Input synchronizer, idles high so reset does not look like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], rx};
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            count_r    <= 4'd0;
            bitcnt_r   <= 3'd0;
            shift_r    <= 8'd0;
            armed_r    <= 1'b0;
            wls_r      <= 2'd0;
            pen_r      <= 1'b0;
            eps_r      <= 1'b0;
            stick_r    <= 1'b0;
            par_err_r  <= 1'b0;
            par_zero_r <= 1'b1;
            push_r     <= 1'b0;
            dout_r     <= 8'd0;
            pe_r       <= 1'b0;
            fe_r       <= 1'b0;
            bi_r       <= 1'b0;
        end else begin
            state_r    <= state_s;
            count_r    <= count_s;
            bitcnt_r   <= bitcnt_s;
            shift_r    <= shift_s;
            armed_r    <= armed_s;
            wls_r      <= wls_s;
            pen_r      <= pen_s;
            eps_r      <= eps_s;
            stick_r    <= stick_s;
            par_err_r  <= par_err_s;
            par_zero_r <= par_zero_s;
            push_r     <= push_s;
            dout_r     <= dout_s;
            pe_r       <= pe_s;
            fe_r       <= fe_s;
            bi_r       <= bi_s;
        end
    end

    // Next-state and output logic; everything advances only on baud_pulse.
    always_comb begin
        state_s    = state_r;
        count_s    = count_r;
        bitcnt_s   = bitcnt_r;
        shift_s    = shift_r;
        armed_s    = armed_r;
        wls_s      = wls_r;
        pen_s      = pen_r;
        eps_s      = eps_r;
        stick_s    = stick_r;
        par_err_s  = par_err_r;
        par_zero_s = par_zero_r;
        push_s     = 1'b0;
        dout_s     = dout_r;
        pe_s       = pe_r;
        fe_s       = fe_r;
        bi_s       = bi_r;

        if (baud_pulse) begin
            case (state_r)
                ST_IDLE: begin
                    if (rxs_s) begin
                        armed_s = 1'b1;
                    end else if (armed_r) begin
                        state_s = ST_START;
                        count_s = 4'd7;
                        armed_s = 1'b0;
                    end else begin
                        armed_s = 1'b0;
                    end
                end
                ST_START: begin
                    if (count_r != 4'd0) begin
                        count_s = count_r - 4'd1;
                    end else if (!rxs_s) begin
                        state_s    = ST_DATA;
                        count_s    = 4'd15;
                        bitcnt_s   = 3'd4 + {1'b0, wls};
                        shift_s    = 8'd0;
                        wls_s      = wls;
                        pen_s      = pen;
                        eps_s      = eps;
                        stick_s    = sticky_parity;
                        par_err_s  = 1'b0;
                        par_zero_s = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                        armed_s = 1'b1;
                    end
                end
                ST_DATA: begin
                    if (count_r != 4'd0) begin
                        count_s = count_r - 4'd1;
                    end else begin
                        shift_s = {rxs_s, shift_r[7:1]};
                        count_s = 4'd15;
                        if (bitcnt_r == 3'd0) begin
                            state_s = pen_r ? ST_PARITY : ST_STOP;
                        end else begin
                            bitcnt_s = bitcnt_r - 3'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (count_r != 4'd0) begin
                        count_s = count_r - 4'd1;
                    end else begin
                        par_err_s  = rxs_s != exp_parity(shift_r, eps_r, stick_r);
                        par_zero_s = ~rxs_s;
                        state_s    = ST_STOP;
                        count_s    = 4'd15;
                    end
                end
                ST_STOP: begin
                    if (count_r != 4'd0) begin
                        count_s = count_r - 4'd1;
                    end else begin
                        push_s  = 1'b1;
                        dout_s  = shift_r >> align_s;
                        pe_s    = pen_r & par_err_r;
                        fe_s    = ~rxs_s;
                        bi_s    = (shift_r == 8'd0) & (~pen_r | par_zero_r) & ~rxs_s;
                        state_s = ST_IDLE;
                        armed_s = rxs_s;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    armed_s = 1'b0;
                end
            endcase
        end else begin
            push_s = 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_top.sv
// Directed bench for uart_rx_top: 16 baud pulses per bit, 4 clks per pulse.
module tb_uart_rx_top;

    logic       clk;
    logic       rst;
    logic       baud_pulse;
    logic       rx;
    logic       pen;
    logic       eps;
    logic       sticky_parity;
    logic [1:0] wls;
    logic       push;
    logic [7:0] dout;
    logic       pe;
    logic       fe;
    logic       bi;

    int checks = 0;
    int errors = 0;
    int push_cnt = 0;
    int push_long = 0;
    logic push_prev = 1'b0;
    int base;

    uart_rx_top #(.SYNC_STAGES(2)) dut (
        .clk(clk),
        .rst(rst),
        .baud_pulse(baud_pulse),
        .rx(rx),
        .pen(pen),
        .eps(eps),
        .sticky_parity(sticky_parity),
        .wls(wls),
        .push(push),
        .dout(dout),
        .pe(pe),
        .fe(fe),
        .bi(bi)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        int bcnt;
        bcnt = 0;
        baud_pulse = 1'b0;
        forever begin
            @(negedge clk);
            baud_pulse = (bcnt == 3);
            bcnt = (bcnt + 1) % 4;
        end
    end

    // Count pushes and any push held for more than one cycle.
    always @(negedge clk) begin
        if (push) begin
            push_cnt <= push_cnt + 1;
            if (push_prev) push_long <= push_long + 1;
        end
        push_prev <= push;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (64) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input int nbits,
                              input logic use_par, input logic par, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < nbits; i++) begin
            drive_bit(data[i]);
        end
        if (use_par) drive_bit(par);
        drive_bit(stop);
        drive_bit(1'b1);
        drive_bit(1'b1);
    endtask

    initial begin
        rst = 1'b0;
        rx = 1'b1;
        pen = 1'b0;
        eps = 1'b0;
        sticky_parity = 1'b0;
        wls = 2'b11;
        repeat (5) @(negedge clk);
        chk("reset_push", {31'd0, push}, 32'd0);
        chk("reset_dout", {24'd0, dout}, 32'd0);
        chk("reset_pe", {31'd0, pe}, 32'd0);
        chk("reset_fe", {31'd0, fe}, 32'd0);
        chk("reset_bi", {31'd0, bi}, 32'd0);
        rst = 1'b1;
        repeat (64) @(negedge clk);

        // 8N1 0xA5
        base = push_cnt;
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
        chk("a5_pushes", push_cnt - base, 32'd1);
        chk("a5_dout", {24'd0, dout}, 32'h0000_00A5);
        chk("a5_pe", {31'd0, pe}, 32'd0);
        chk("a5_fe", {31'd0, fe}, 32'd0);
        chk("a5_bi", {31'd0, bi}, 32'd0);

        // 7E1 0x35 (four ones): good parity 0, then bad parity 1
        wls = 2'b10; pen = 1'b1; eps = 1'b1;
        base = push_cnt;
        send_frame(8'h35, 7, 1'b1, 1'b0, 1'b1);
        chk("7e1_good_pushes", push_cnt - base, 32'd1);
        chk("7e1_good_dout", {24'd0, dout}, 32'h0000_0035);
        chk("7e1_good_pe", {31'd0, pe}, 32'd0);
        base = push_cnt;
        send_frame(8'h35, 7, 1'b1, 1'b1, 1'b1);
        chk("7e1_bad_pushes", push_cnt - base, 32'd1);
        chk("7e1_bad_dout", {24'd0, dout}, 32'h0000_0035);
        chk("7e1_bad_pe", {31'd0, pe}, 32'd1);

        // 5-bit stick parity, eps=0 -> expected parity bit 1
        wls = 2'b00; pen = 1'b1; eps = 1'b0; sticky_parity = 1'b1;
        base = push_cnt;
        send_frame(8'h1F, 5, 1'b1, 1'b1, 1'b1);
        chk("stick_good_pushes", push_cnt - base, 32'd1);
        chk("stick_good_dout", {24'd0, dout}, 32'h0000_001F);
        chk("stick_good_pe", {31'd0, pe}, 32'd0);
        base = push_cnt;
        send_frame(8'h1F, 5, 1'b1, 1'b0, 1'b1);
        chk("stick_bad_pushes", push_cnt - base, 32'd1);
        chk("stick_bad_dout", {24'd0, dout}, 32'h0000_001F);
        chk("stick_bad_pe", {31'd0, pe}, 32'd1);

        // 8N1 0x55 with stop bit 0
        wls = 2'b11; pen = 1'b0; eps = 1'b0; sticky_parity = 1'b0;
        base = push_cnt;
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0);
        chk("fe_pushes", push_cnt - base, 32'd1);
        chk("fe_dout", {24'd0, dout}, 32'h0000_0055);
        chk("fe_fe", {31'd0, fe}, 32'd1);
        chk("fe_bi", {31'd0, bi}, 32'd0);

        // Break: line low for three frame times
        base = push_cnt;
        rx = 1'b0;
        repeat (3 * 10 * 64) @(negedge clk);
        chk("brk_pushes", push_cnt - base, 32'd1);
        chk("brk_dout", {24'd0, dout}, 32'd0);
        chk("brk_fe", {31'd0, fe}, 32'd1);
        chk("brk_bi", {31'd0, bi}, 32'd1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        base = push_cnt;
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1);
        chk("post_brk_pushes", push_cnt - base, 32'd1);
        chk("post_brk_dout", {24'd0, dout}, 32'h0000_003C);
        chk("post_brk_flags", {29'd0, bi, fe, pe}, 32'd0);

        // Low glitch of 5 baud pulses
        base = push_cnt;
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (1280) @(negedge clk);
        chk("glitch_pushes", push_cnt - base, 32'd0);

        // Reset in the middle of a data bit of 0x81
        base = push_cnt;
        drive_bit(1'b0);
        drive_bit(1'b1);
        rx = 1'b0;
        repeat (32) @(negedge clk);
        #2 rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrst_dout", {24'd0, dout}, 32'd0);
        rx = 1'b1;
        rst = 1'b1;
        repeat (1280) @(negedge clk);
        chk("midrst_pushes", push_cnt - base, 32'd0);
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1);
        chk("after_rst_pushes", push_cnt - base, 32'd1);
        chk("after_rst_dout", {24'd0, dout}, 32'h0000_0081);

        chk("push_one_cycle", push_long, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_top.md
Name: uart_rx_top

Overview:
- UART receive engine; the receive half of the UART, paired with the transmit engine and the same baud generator.
- Samples the serial line using a 16x oversampling baud_pulse and deserialises 5–8 data bits, LSB first.
- Checks optional parity and the stop bit, and detects break.
- Pushes each completed character plus its error flags into the RX FIFO with a one-cycle push strobe.

Parameters:
- SYNC_STAGES, 2: number of flip-flops in the rx input synchronizer (minimum 2).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low (0 = reset)
- baud_pulse  in  1  one-clk-wide enable at 16x the bit rate
- rx  in  1  asynchronous serial input; idles high
- pen  in  1  parity enable
- eps  in  1  even parity select (1 = even, 0 = odd)
- sticky_parity  in  1  stick parity; expected parity bit = ~eps
- wls  in  2  word length select; data bits = 5 + wls
- push  out  1  one-clk strobe: write {bi,fe,pe,dout} to the RX FIFO
- dout  out  8  received character, right-justified; unused upper bits 0
- pe  out  1  parity error for the character in dout
- fe  out  1  framing error (stop bit sampled 0)
- bi  out  1  break indicator

Behaviour:
- Reset (rst=0, asynchronous):
  - state=idle; push=0, dout=0, pe=0, fe=0, bi=0.
  - Synchronizer flops are set to 1; internal counters are cleared.
  - Reset asserted mid-frame abandons the frame; no push is issued.
- Sampling:
  - rx passes through SYNC_STAGES flops; rxs is the last stage.
  - All state changes occur only on clk edges where baud_pulse=1.
  - wls, pen, eps and sticky_parity are sampled when the start bit is qualified and held for the whole frame.
- State idle:
  - An armed receiver seeing rxs=0 goes to start with count=7.
  - The receiver re-arms only after rxs has been seen 1 in idle. This prevents a held-low line from retriggering.
- State start:
  - Decrement count each pulse. At count=0 (the start-bit midpoint), check rxs.
  - rxs=0: go to data with count=15, bitcnt=4+wls.
  - rxs=1: false start; return to idle, armed, with no push.
- State data:
  - Decrement count. At count=0, shift rxs into the MSB side of the data register and reload count=15.
  - When bitcnt=0, go to parity if pen=1, else to stop. Otherwise decrement bitcnt.
  - Final alignment: dout bits [4+wls:0] = received bits with bit0 = first bit received; higher bits = 0.
- State parity:
  - At count=0, sample the parity bit; go to stop with count=15.
  - Expected parity bit:
    - sticky_parity=1: ~eps.
    - sticky_parity=0, eps=1: XOR of data bits.
    - sticky_parity=0, eps=0: inverse of that XOR.
  - pe = sampled bit != expected bit.
- State stop:
  - At count=0, sample the stop bit; fe = ~rxs.
  - bi = 1 if all data bits, the parity bit (when pen=1) and the stop bit sampled 0.
  - Set dout, pe, fe, bi and push=1 on this edge; return to idle.
  - Re-arm immediately if rxs=1; if rxs=0, wait for rxs=1.
- Checking and output timing:
  - Only one stop bit is checked, regardless of stop-bit setting.
  - push is high for exactly one clk cycle: it clears on the next clk edge even without baud_pulse.
  - dout, pe, fe and bi hold their values until the next push.
- Latency: push rises 1 clk after the baud_pulse edge that samples the stop bit's midpoint (about 8 pulses into the stop bit).
- Glitch rejection: a low pulse shorter than 8 baud pulses is ignored, with no push.
- Back-to-back frames: a new start bit detected on the first armed idle pulse after push is received correctly.

Test Plan:
- 8N1 (wls=11, pen=0), drive 0xA5 at 16 pulses/bit → one push; dout=0xA5, pe=fe=bi=0.
- 7E1 (wls=10, pen=1, eps=1), drive 0x35 with parity bit 0 → dout=0x35, pe=0. Repeat with parity bit 1 → pe=1, dout=0x35.
- 5-bit sticky (wls=00, pen=1, sticky_parity=1, eps=0), drive 0x1F with parity bit 1 → dout=0x1F, pe=0. Repeat with parity bit 0 → pe=1.
- 8N1, drive 0x55 with stop bit 0 → push, dout=0x55, fe=1, bi=0.
- Hold rx low for 3 frame times → exactly one push with dout=0x00, fe=1, bi=1.
  - No further push until rx returns high; then drive 0x3C → dout=0x3C, flags 0.
- Low glitch of 5 baud pulses → no push.
- Assert rst=0 mid-data-bit, release, then send 0x81 → no push for the aborted frame; one push with dout=0x81.
